// File: rtl/conv_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_streamer
//  Description : Captures the convolution wrapper's ROWS x COLS parallel
//                result array on each rising edge of done_in and streams it
//                out row-major as a valid/ready word stream.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            system clock, all logic on posedge
//    rst_n          synchronous active-low reset
//    done_in        wrapper done flag (level)
//    result_in      parallel result array [ROWS][COLS] of DATA_W words
//    cycle_count_in wrapper cycle count (trailer word source)
//    m_data/m_valid/m_ready/m_last   output word stream
//    m_row/m_col    zero-extended index of the word being presented
//    busy           frame in progress
//    frame_count    completed frames (wraps)
//    overrun        sticky: capture edge seen while a frame was in flight
//  Build option
//    CONV_STREAM_TRAILER_EN : append one trailer word carrying the captured
//                             cycle_count_in (row/col = F/F) after the array.
// ============================================================================
module conv_result_streamer #(
    parameter int ROWS   = 8,
    parameter int COLS   = 10,
    parameter int DATA_W = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     done_in,
    input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]    result_in,
    input  logic [31:0]                              cycle_count_in,
    output logic [DATA_W-1:0]                        m_data,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic                                     m_last,
    output logic [3:0]                               m_row,
    output logic [3:0]                               m_col,
    output logic                                     busy,
    output logic [15:0]                              frame_count,
    output logic                                     overrun
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SEND    = 2'd1;
`ifdef CONV_STREAM_TRAILER_EN
    localparam logic [1:0] c_ST_TRAILER = 2'd2;
`endif

    localparam logic [3:0] c_ROW_LAST = 4'(ROWS - 1);
    localparam logic [3:0] c_COL_LAST = 4'(COLS - 1);

    logic [1:0]                               state_q, state_d;
    logic                                     done_prev_q;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]    buf_q, buf_d;
    logic [3:0]                               row_q, row_d;
    logic [3:0]                               col_q, col_d;
    logic [15:0]                              fc_q, fc_d;
    logic                                     ovr_q, ovr_d;

    logic                                     w_capture;
    logic                                     w_hs;
    logic                                     w_last_cell;
    logic [RW-1:0]                            w_row_idx;
    logic [CW-1:0]                            w_col_idx;

`ifdef CONV_STREAM_TRAILER_EN
    logic [DATA_W-1:0]                        cyc_q, cyc_d;
    logic [DATA_W-1:0]                        w_cyc_ext;

    // Fit the 32-bit cycle count to the stream word width.
    if (DATA_W > 32) begin : g_cyc_wide
        assign w_cyc_ext = {{(DATA_W-32){1'b0}}, cycle_count_in};
    end else if (DATA_W == 32) begin : g_cyc_equal
        assign w_cyc_ext = cycle_count_in;
    end else begin : g_cyc_narrow
        assign w_cyc_ext = cycle_count_in[DATA_W-1:0];
    end
`else
    // Cycle count has no consumer without the trailer word.
    logic w_unused_cycle_count;
    assign w_unused_cycle_count = ^cycle_count_in;
`endif

    assign w_capture   = done_in & ~done_prev_q;
    assign m_valid     = (state_q != c_ST_IDLE);
    assign busy        = (state_q != c_ST_IDLE);
    assign w_hs        = m_valid & m_ready;
    assign w_last_cell = (row_q == c_ROW_LAST) && (col_q == c_COL_LAST);
    assign w_row_idx   = row_q[RW-1:0];
    assign w_col_idx   = col_q[CW-1:0];

    assign m_row       = row_q;
    assign m_col       = col_q;
    assign frame_count = fc_q;
    assign overrun     = ovr_q;

    // Output word is a mux off the capture buffer, so it is inherently stable
    // while the index registers hold during a stall.
    always_comb begin
        m_data = buf_q[w_row_idx][w_col_idx];
        m_last = (state_q == c_ST_SEND) && w_last_cell;
`ifdef CONV_STREAM_TRAILER_EN
        m_last = (state_q == c_ST_TRAILER);
        if (state_q == c_ST_TRAILER) begin
            m_data = cyc_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        row_d   = row_q;
        col_d   = col_q;
        fc_d    = fc_q;
        ovr_d   = ovr_q;
`ifdef CONV_STREAM_TRAILER_EN
        cyc_d   = cyc_q;
`endif

        // A capture edge outside IDLE is dropped; the buffer stays intact.
        if (w_capture && (state_q != c_ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            c_ST_IDLE: begin
                if (w_capture) begin
                    buf_d   = result_in;
`ifdef CONV_STREAM_TRAILER_EN
                    cyc_d   = w_cyc_ext;
`endif
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    state_d = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (w_hs) begin
                    if (w_last_cell) begin
`ifdef CONV_STREAM_TRAILER_EN
                        state_d = c_ST_TRAILER;
                        row_d   = 4'hF;
                        col_d   = 4'hF;
`else
                        state_d = c_ST_IDLE;
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                        fc_d    = fc_q + 16'd1;
`endif
                    end else if (col_q == c_COL_LAST) begin
                        col_d = 4'd0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
`ifdef CONV_STREAM_TRAILER_EN
            c_ST_TRAILER: begin
                if (w_hs) begin
                    state_d = c_ST_IDLE;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    fc_d    = fc_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= c_ST_IDLE;
            done_prev_q <= 1'b0;
            buf_q       <= '0;
            row_q       <= 4'd0;
            col_q       <= 4'd0;
            fc_q        <= 16'd0;
            ovr_q       <= 1'b0;
`ifdef CONV_STREAM_TRAILER_EN
            cyc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            done_prev_q <= done_in;
            buf_q       <= buf_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fc_q        <= fc_d;
            ovr_q       <= ovr_d;
`ifdef CONV_STREAM_TRAILER_EN
            cyc_q       <= cyc_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_result_streamer
//  Description : Directed self-checking bench for conv_result_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_streamer;

    localparam int ROWS   = 8;
    localparam int COLS   = 10;
    localparam int DATA_W = 32;
`ifdef CONV_STREAM_TRAILER_EN
    localparam int FRAME_LEN = ROWS*COLS + 1;
`else
    localparam int FRAME_LEN = ROWS*COLS;
`endif

    typedef logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] arr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              done_in;
    arr_t              result_in;
    logic [31:0]       cycle_count_in;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [3:0]        m_row;
    logic [3:0]        m_col;
    logic              busy;
    logic [15:0]       frame_count;
    logic              overrun;

    int n_vec = 0;
    int n_bad = 0;

    conv_result_streamer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .done_in        (done_in),
        .result_in      (result_in),
        .cycle_count_in (cycle_count_in),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .m_row          (m_row),
        .m_col          (m_col),
        .busy           (busy),
        .frame_count    (frame_count),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] all_outs();
        return {m_data, m_valid, m_last, m_row, m_col, busy, frame_count, overrun};
    endfunction

    // Receive one frame and compare every accepted word against exp.
    // bp selects the 1,0,0,1 ready pattern; done_level is driven on done_in
    // each cycle; at word ovr_at a one-cycle done pulse with new_data is sent.
    task automatic recv(input arr_t exp, input bit bp, input logic done_level,
                        input int ovr_at, input arr_t new_data, output int ncyc);
        int k = 0;
        int cyc = 0;
        bit stalled = 0;
        bit ovr_sent = 0;
        logic [40:0] prev = '0;
        logic [40:0] cur;
        logic [40:0] e;
        int r, c;
        logic lst;
        while (k < FRAME_LEN && cyc < 2000) begin
            m_ready = bp ? (((cyc % 4) == 0) || ((cyc % 4) == 3)) : 1'b1;
            done_in = done_level;
            if (k == ovr_at && !ovr_sent) begin
                done_in   = 1'b1;
                result_in = new_data;
                ovr_sent  = 1;
            end
            if (m_valid) begin
                cur = {m_data, m_row, m_col, m_last};
                if (stalled) chk("hold_stable", cur, prev);
                if (m_ready) begin
                    if (k < ROWS*COLS) begin
                        r = k / COLS;
                        c = k % COLS;
`ifdef CONV_STREAM_TRAILER_EN
                        lst = 1'b0;
`else
                        lst = (k == ROWS*COLS - 1);
`endif
                        e = {exp[r][c], 4'(r), 4'(c), lst};
                    end else begin
                        e = {32'd1234, 4'hF, 4'hF, 1'b1};
                    end
                    chk($sformatf("word%0d", k), cur, e);
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = cur;
                end
            end else begin
                chk("valid_present", m_valid, 1'b1);
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        chk("frame_words", k, FRAME_LEN);
        ncyc = cyc;
    endtask

    arr_t a_basic, a_bp, a_new;
    int   used;

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                a_basic[r][c] = 32'(r*10 + c);
                a_bp[r][c]    = 32'hA000_0000 + 32'(r*16 + c);
                a_new[r][c]   = 32'h5500_0000 + 32'(r*100 + c*3);
            end
        end
        rst_n = 1'b0; done_in = 1'b0; m_ready = 1'b0;
        result_in = a_basic; cycle_count_in = 32'd1234;

        // Reset, then idle with ready asserted.
        repeat (3) tick();
        chk("reset_outs", all_outs(), 60'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_no_valid", {m_valid, busy}, 2'b00);
        end
        m_ready = 1'b0;

        // Basic frame: one-cycle latency, full ready.
        done_in = 1'b1;
        chk("pre_edge_valid", m_valid, 1'b0);
        tick();
        chk("latency_valid_busy", {m_valid, busy}, 2'b11);
        recv(a_basic, 1'b0, 1'b0, -1, a_basic, used);
        chk("basic_end", {m_valid, busy, frame_count, overrun}, {2'b00, 16'd1, 1'b0});

        // Back-pressure frame.
        result_in = a_bp;
        done_in = 1'b1;
        tick();
        recv(a_bp, 1'b1, 1'b0, -1, a_bp, used);
        chk("bp_end", {m_valid, busy, frame_count, overrun}, {2'b00, 16'd2, 1'b0});

        // Reset mid-frame abandons the frame.
        result_in = a_basic;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        m_ready = 1'b1;
        repeat (5) tick();
        chk("midframe_word", {m_data, m_row, m_col}, {32'd5, 4'd0, 4'd5});
        rst_n = 1'b0;
        m_ready = 1'b0;
        tick();
        chk("midframe_reset_outs", all_outs(), 60'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {m_valid, m_last, busy}, 3'b000);

        // Level done held for 200 cycles yields one frame.
        done_in = 1'b1;
        tick();
        recv(a_basic, 1'b0, 1'b1, -1, a_basic, used);
        for (int i = used + 1; i < 200; i++) begin
            tick();
            chk("level_no_refire", m_valid, 1'b0);
        end
        chk("level_end", {frame_count, overrun}, {16'd1, 1'b0});
        done_in = 1'b0;
        tick();

        // Overrun: edge with new data at word 40, frame continues from old data.
        result_in = a_bp;
        done_in = 1'b1;
        tick();
        recv(a_bp, 1'b0, 1'b0, 40, a_new, used);
        chk("overrun_end", {m_valid, frame_count, overrun}, {1'b0, 16'd2, 1'b1});
        done_in = 1'b1;
        tick();
        recv(a_new, 1'b0, 1'b0, -1, a_new, used);
        chk("frame2_end", {frame_count, overrun}, {16'd3, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Output-side counterpart of the convolution wrapper.
- On each rising edge of the wrapper's done flag, captures the ROWS x COLS parallel result array.
- Serialises the captured array as a row-major valid/ready word stream to a downstream consumer (UART/host bridge, result RAM writer).
- Decouples the wide parallel result bus from a narrow back-pressured sink.

Parameters:
- ROWS, 8, result rows.
- COLS, 10, result columns.
- DATA_W, 32, result word width.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- done_in  in  1  wrapper done flag (level, may stay high for many cycles).
- result_in  in  DATA_W x [ROWS][COLS]  parallel result array; valid while done_in high.
- cycle_count_in  in  32  wrapper cycle count; valid while done_in high.
- m_data  out  DATA_W  stream word.
- m_valid  out  1  word available.
- m_ready  in  1  sink accepts word.
- m_last  out  1  final word of frame.
- m_row  out  4  row index of current word.
- m_col  out  4  column index of current word.
- busy  out  1  frame capture or send in progress.
- frame_count  out  16  completed frames, wraps at 65535 -> 0.
- overrun  out  1  sticky: capture edge arrived while not IDLE.

Behaviour:
- Reset (rst_n low at posedge) clears every output and internal register:
  - m_data=0, m_valid=0, m_last=0, m_row=0, m_col=0, busy=0, frame_count=0, overrun=0.
  - done_prev=0, state=IDLE, capture buffer=0.
- Reset mid-frame abandons the frame immediately, with no partial m_last.
- Edge detect: done_prev registers done_in every cycle. Capture event = done_in && !done_prev.
- States are IDLE, SEND, and TRAILER (TRAILER exists only with the optional feature).
- IDLE:
  - On a capture event, copy result_in (and cycle_count_in) into an internal buffer.
  - Set row=0, col=0, state=SEND, busy=1.
  - The next cycle presents m_valid=1 with m_data=buffer[0][0]. Latency is capture edge to first m_valid = 1 cycle.
- SEND:
  - m_data=buffer[m_row][m_col] and m_valid=1.
  - Handshake occurs when m_valid && m_ready.
  - On handshake, col increments. At col==COLS-1, col returns to 0 and row increments.
  - m_last=1 only on word (ROWS-1, COLS-1).
  - After the handshake on that word: go to IDLE, m_valid=0, busy=0, and frame_count increments, all at the same edge.
- Stream rules:
  - While m_valid && !m_ready, m_data, m_last, m_row and m_col must hold stable.
  - m_valid never drops without a handshake.
  - m_ready high while m_valid is low has no effect.
- Capture event in any state other than IDLE:
  - Ignored; the buffer is not disturbed.
  - overrun is set to 1 and stays set until reset.
  - This includes an edge coinciding with the final handshake cycle.
- done_in held high produces exactly one frame. A new frame requires done_in to go low and then high again.
- Frame length is ROWS*COLS = 80 words. m_row and m_col are zero-extended indices.

Optional Feature:
- Macro: CONV_STREAM_TRAILER_EN.
- Defined:
  - The final array word (ROWS-1, COLS-1) has m_last=0.
  - The FSM then enters TRAILER and presents one extra word: m_data=captured cycle_count_in (zero-extended/truncated to DATA_W), m_row=4'hF, m_col=4'hF, m_last=1.
  - Frame length is 81. frame_count increments on the trailer handshake.
- Not defined:
  - TRAILER state and cycle_count buffer are absent. cycle_count_in is unused.
  - Frame length is 80.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release with done_in=0 -> all outputs 0 and m_valid stays 0 for 20 cycles.
- Basic frame: result_in[r][c]=r*10+c, pulse done_in, m_ready=1 -> m_valid rises the cycle after the edge.
  - 80 consecutive words 0..79 with correct row/col.
  - m_last only on word 79 (row 7, col 9).
  - frame_count=1, busy=0 afterwards.
- Back-pressure: m_ready toggles 1,0,0,1 repeating, result_in[r][c]=32'hA000_0000+r*16+c -> every word held stable while stalled.
  - 80 words received in order with no duplicates or gaps.
- Level done: hold done_in=1 for 200 cycles -> exactly one frame; frame_count=1; overrun=0.
- Overrun: second done_in rising edge at word 40 with a changed result_in -> overrun=1.
  - The remaining words come from the original capture.
  - After the frame completes, a fresh edge in IDLE starts frame 2 with the new data.
  - overrun is still 1.
- Trailer (macro defined): cycle_count_in=32'd1234 -> 81 words.
  - Word 79 has m_last=0.
  - Word 80 is 1234 with row/col=F/F and m_last=1.
